// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall controller bus.
// Groups the ID/EXE hazard inputs and the pipeline-control outputs of
// hazard_stall_unit. The master modport belongs to the pipeline, which
// drives the hazard inputs. The slave modport belongs to the controller.
// STALL_COUNT exists only when STALL_PERF_COUNT_EN is defined.
interface hazard_stall_unit_if;
    logic [4:0]  ID_ADDR1;
    logic [4:0]  ID_ADDR2;
    logic [6:0]  ID_OPCODE;
    logic [4:0]  EXE_ADDR;
    logic        EXE_MEMREAD;
    logic        EXE_MULDIV;
    logic        MULDIV_DONE;
    logic        BJ_TAKEN;
    logic        PC_WRITE;
    logic        IF_ID_WRITE;
    logic        IF_ID_FLUSH;
    logic        ID_EXE_BUBBLE;
    logic        EXE_HOLD;
    logic        EXE_MEM_BUBBLE;
    logic        MULDIV_ERR;
    logic [1:0]  STATE;
`ifdef STALL_PERF_COUNT_EN
    logic [31:0] STALL_COUNT;
`endif

    modport master (
        output ID_ADDR1, ID_ADDR2, ID_OPCODE, EXE_ADDR, EXE_MEMREAD,
               EXE_MULDIV, MULDIV_DONE, BJ_TAKEN,
        input  PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EXE_BUBBLE, EXE_HOLD,
               EXE_MEM_BUBBLE, MULDIV_ERR, STATE
`ifdef STALL_PERF_COUNT_EN
        , input STALL_COUNT
`endif
    );

    modport slave (
        input  ID_ADDR1, ID_ADDR2, ID_OPCODE, EXE_ADDR, EXE_MEMREAD,
               EXE_MULDIV, MULDIV_DONE, BJ_TAKEN,
        output PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EXE_BUBBLE, EXE_HOLD,
               EXE_MEM_BUBBLE, MULDIV_ERR, STATE
`ifdef STALL_PERF_COUNT_EN
        , output STALL_COUNT
`endif
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: pipeline interlock controller for the RV32IM 5-stage core.
// It stalls PC and IF/ID and injects bubbles on load-use hazards. It holds
// EXE while a multi-cycle DIV/REM runs, with a watchdog release. It flushes
// IF/ID and ID/EXE on a taken branch or jump.
// Ports:
//   CLK, RESET   clock and asynchronous active-high reset
//   hz (slave)   hazard inputs from ID/EXE, pipeline enables and bubbles out,
//                STATE for debug, STALL_COUNT when STALL_PERF_COUNT_EN is set
// Parameters: LOAD_STALL_CYCLES (1..7), MULDIV_TIMEOUT (2..255)
// Optional feature macro: STALL_PERF_COUNT_EN (free-running stall-cycle count)
module hazard_stall_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MULDIV_TIMEOUT    = 40
) (
    input logic           CLK,
    input logic           RESET,
    hazard_stall_unit_if.slave hz
);
    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MULDIV     = 2'b10
    } state_t;

    localparam logic [7:0] LS_RELOAD = 8'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] TMO       = 8'(MULDIV_TIMEOUT);

    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_t     state;
    logic [7:0] cnt;

    logic rs1_used, rs2_used, load_use;
    logic pc_write, if_id_write, if_id_flush, id_exe_bubble;
    logic exe_hold, exe_mem_bubble, muldiv_err;

    // A field counts as a source only when the opcode reads that register.
    // This keeps immediate bits in the rs2 slot from raising false hazards.
    always_comb begin
        rs1_used = (hz.ID_OPCODE == OPC_JALR)  || (hz.ID_OPCODE == OPC_LOAD)  ||
                   (hz.ID_OPCODE == OPC_STORE) || (hz.ID_OPCODE == OPC_OPIMM) ||
                   (hz.ID_OPCODE == OPC_OP)    || (hz.ID_OPCODE == OPC_BRANCH);
        rs2_used = (hz.ID_OPCODE == OPC_STORE) || (hz.ID_OPCODE == OPC_OP) ||
                   (hz.ID_OPCODE == OPC_BRANCH);
    end

    assign load_use = hz.EXE_MEMREAD && (hz.EXE_ADDR != 5'd0) &&
                      ((rs1_used && (hz.ID_ADDR1 == hz.EXE_ADDR)) ||
                       (rs2_used && (hz.ID_ADDR2 == hz.EXE_ADDR)));

    // Outputs respond in the same cycle as the hazard. RESET forces the
    // no-stall defaults regardless of state or inputs.
    always_comb begin
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_exe_bubble  = 1'b0;
        exe_hold       = 1'b0;
        exe_mem_bubble = 1'b0;
        muldiv_err     = 1'b0;
        if (!RESET) begin
            case (state)
                RUN: begin
                    if (hz.BJ_TAKEN) begin
                        if_id_flush   = 1'b1;
                        id_exe_bubble = 1'b1;
                    end else if (hz.EXE_MULDIV) begin
                        if (!hz.MULDIV_DONE) begin
                            pc_write       = 1'b0;
                            if_id_write    = 1'b0;
                            exe_hold       = 1'b1;
                            exe_mem_bubble = 1'b1;
                        end
                    end else if (load_use) begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_exe_bubble = 1'b1;
                    end
                end
                // EXE holds only bubbles here, so BJ_TAKEN cannot be real.
                LOAD_STALL: begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_exe_bubble = 1'b1;
                end
                MULDIV: begin
                    if (hz.MULDIV_DONE) begin
                        // release: defaults
                    end else if (cnt == TMO) begin
                        muldiv_err = 1'b1;
                    end else begin
                        pc_write       = 1'b0;
                        if_id_write    = 1'b0;
                        exe_hold       = 1'b1;
                        exe_mem_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // LOAD_STALL counts down the remaining bubbles.
    // MULDIV counts wait cycles up toward the watchdog limit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hz.BJ_TAKEN) begin
                        state <= RUN;
                    end else if (hz.EXE_MULDIV) begin
                        if (!hz.MULDIV_DONE) begin
                            cnt   <= 8'd1;
                            state <= MULDIV;
                        end
                    end else if (load_use && (LOAD_STALL_CYCLES > 1)) begin
                        cnt   <= LS_RELOAD;
                        state <= LOAD_STALL;
                    end
                end
                LOAD_STALL: begin
                    if (cnt <= 8'd1) begin
                        cnt   <= 8'd0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                MULDIV: begin
                    if (hz.MULDIV_DONE || (cnt >= TMO)) begin
                        cnt   <= 8'd0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    cnt   <= 8'd0;
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef STALL_PERF_COUNT_EN
    logic [31:0] stall_cnt;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)         stall_cnt <= 32'd0;
        else if (!pc_write) stall_cnt <= stall_cnt + 32'd1;
    end
    assign hz.STALL_COUNT = stall_cnt;
`endif

    assign hz.PC_WRITE       = pc_write;
    assign hz.IF_ID_WRITE    = if_id_write;
    assign hz.IF_ID_FLUSH    = if_id_flush;
    assign hz.ID_EXE_BUBBLE  = id_exe_bubble;
    assign hz.EXE_HOLD       = exe_hold;
    assign hz.EXE_MEM_BUBBLE = exe_mem_bubble;
    assign hz.MULDIV_ERR     = muldiv_err;
    assign hz.STATE          = state;
endmodule
